// File: rtl/ntt_stage_scheduler.sv
// Sequences one iterative N-point NTT: LOG_N stages of N/P read beats, ping-ponging two banks, with a drain gap per stage.
// Reads begin 1 cycle after inStart and writes trail by PIPE_LAT; there is no backpressure, and abort is the only way to stop a run.
module ntt_stage_scheduler #(
  parameter int N               = 1024,
  parameter int INPUT_PER_CYCLE = 32,
  parameter int LOG_N           = 10,
  parameter int PIPE_LAT        = 4,
  parameter int TW_ADDR_W       = 9,
  localparam int BEATS   = N / INPUT_PER_CYCLE,
  localparam int BEAT_W  = $clog2(BEATS),
  localparam int STAGE_W = $clog2(LOG_N),
  localparam int DCNT_W  = $clog2(PIPE_LAT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inStart,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic                 rd_bank,
  output logic [STAGE_W-1:0]   stage_idx,
  output logic [BEAT_W-1:0]    beat_idx,
  output logic [TW_ADDR_W-1:0] tw_addr,
  output logic                 wr_en,
  output logic                 wr_bank,
  output logic [BEAT_W-1:0]    wr_beat,
  output logic [STAGE_W-1:0]   perm_sel
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic               vld;
    logic               bank;
    logic [BEAT_W-1:0]  beat;
    logic [STAGE_W-1:0] stage;
  } wr_slot_t;

  state_e                    state_q, state_d;
  logic [STAGE_W-1:0]        stage_q, stage_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [DCNT_W-1:0]         dcnt_q, dcnt_d;
  wr_slot_t [PIPE_LAT-1:0]   dly_q, dly_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      beat_q  <= '0;
      dcnt_q  <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      beat_q  <= beat_d;
      dcnt_q  <= dcnt_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    beat_d  = beat_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (inStart) begin
          state_d = S_RUN;
          stage_d = '0;
          beat_d  = '0;
        end
      end
      S_RUN: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          state_d = S_DRAIN;
          beat_d  = '0;
          dcnt_d  = '0;
        end
      end
      S_DRAIN: begin
        // Hold off the next stage until the last write of this one has landed.
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == DCNT_W'(PIPE_LAT - 1)) begin
          dcnt_d = '0;
          if (stage_q == STAGE_W'(LOG_N - 1)) begin
            state_d = S_DONE;
            stage_d = '0;
          end else begin
            state_d = S_RUN;
            stage_d = stage_q + 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      stage_d = '0;
      beat_d  = '0;
      dcnt_d  = '0;
    end
  end

  always_comb begin
    rd_en     = (state_q == S_RUN);
    busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    done      = (state_q == S_DONE);
    rd_bank   = stage_q[0];
    stage_idx = stage_q;
    beat_idx  = beat_q;
    tw_addr   = '0;
    if (state_q == S_RUN) begin
      tw_addr = TW_ADDR_W'(stage_q) * TW_ADDR_W'(BEATS) + TW_ADDR_W'(beat_q);
    end
  end

  // Only live reads enter the line, so idle slots read back as all-zero.
  always_comb begin
    dly_d = dly_q;
    dly_d[0] = '0;
    if (rd_en) begin
      dly_d[0].vld   = 1'b1;
      dly_d[0].bank  = rd_bank;
      dly_d[0].beat  = beat_q;
      dly_d[0].stage = stage_q;
    end
    for (int i = 1; i < PIPE_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
    if (abort) begin
      dly_d = '0;
    end
  end

  always_comb begin
    wr_en    = dly_q[PIPE_LAT-1].vld;
    wr_bank  = dly_q[PIPE_LAT-1].vld & ~dly_q[PIPE_LAT-1].bank;
    wr_beat  = dly_q[PIPE_LAT-1].beat;
    perm_sel = dly_q[PIPE_LAT-1].stage;
  end

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Scoreboard bench: three schedulers (PIPE_LAT 4, 1, 7) share stimulus and are checked against a per-cycle arithmetic model.
module tb_ntt_stage_scheduler;
  localparam int N     = 1024;
  localparam int P     = 32;
  localparam int LOG_N = 10;
  localparam int BEATS = N / P;
  localparam int NL    = 3;
  localparam int MAXC  = 16384;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic       rd_bank;
    logic [3:0] stage;
    logic [4:0] beat;
    logic [8:0] tw;
    logic       wr_en;
    logic       wr_bank;
    logic [4:0] wr_beat;
    logic [3:0] perm;
  } out_t;

  typedef struct packed {
    int                c;
    out_t [NL-1:0]     e;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_start;
  logic abort_i;

  logic       busy_o   [NL];
  logic       done_o   [NL];
  logic       rd_en_o  [NL];
  logic       rd_bank_o[NL];
  logic [3:0] stage_o  [NL];
  logic [4:0] beat_o   [NL];
  logic [8:0] tw_o     [NL];
  logic       wr_en_o  [NL];
  logic       wr_bank_o[NL];
  logic [4:0] wr_beat_o[NL];
  logic [3:0] perm_o   [NL];

  for (genvar g = 0; g < NL; g++) begin : g_dut
    ntt_stage_scheduler #(
      .N(N), .INPUT_PER_CYCLE(P), .LOG_N(LOG_N),
      .PIPE_LAT(g == 0 ? 4 : (g == 1 ? 1 : 7)), .TW_ADDR_W(9)
    ) u_dut (
      .clk(clk), .rst(rst_n), .inStart(in_start), .abort(abort_i),
      .busy(busy_o[g]), .done(done_o[g]), .rd_en(rd_en_o[g]), .rd_bank(rd_bank_o[g]),
      .stage_idx(stage_o[g]), .beat_idx(beat_o[g]), .tw_addr(tw_o[g]),
      .wr_en(wr_en_o[g]), .wr_bank(wr_bank_o[g]), .wr_beat(wr_beat_o[g]), .perm_sel(perm_o[g])
    );
  end

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;
  int   last_done0 = -1;
  int   start_c [NL];
  bit   hv [NL][MAXC];
  logic [3:0] hs [NL][MAXC];
  logic [4:0] hb [NL][MAXC];
  ev_t  expq[$];

  function automatic int pl_of(input int l);
    return (l == 0) ? 4 : ((l == 1) ? 1 : 7);
  endfunction

  function automatic out_t get_act(input int l);
    out_t a;
    a.busy = busy_o[l];   a.done = done_o[l];   a.rd_en = rd_en_o[l];   a.rd_bank = rd_bank_o[l];
    a.stage = stage_o[l]; a.beat = beat_o[l];   a.tw = tw_o[l];
    a.wr_en = wr_en_o[l]; a.wr_bank = wr_bank_o[l]; a.wr_beat = wr_beat_o[l]; a.perm = perm_o[l];
    return a;
  endfunction

  // Cycle k after acceptance: stage k/period, beat k%period while that is < BEATS, done at LOG_N*period.
  function automatic out_t model(input int l, input int c);
    out_t e;
    int pl, per, k;
    pl  = pl_of(l);
    per = BEATS + pl;
    e   = '0;
    if (start_c[l] >= 0) begin
      k = c - start_c[l] - 1;
      if (k >= 0 && k < LOG_N * per) begin
        e.busy    = 1'b1;
        e.stage   = 4'(k / per);
        e.rd_bank = e.stage[0];
        if (k % per < BEATS) begin
          e.rd_en = 1'b1;
          e.beat  = 5'(k % per);
          e.tw    = 9'((k / per) * BEATS + (k % per));
        end
      end else if (k == LOG_N * per) begin
        e.done = 1'b1;
      end
    end
    if (c >= pl && hv[l][c-pl]) begin
      e.wr_en   = 1'b1;
      e.wr_bank = ~hs[l][c-pl][0];
      e.wr_beat = hb[l][c-pl];
      e.perm    = hs[l][c-pl];
    end
    return e;
  endfunction

  function automatic bit idle(input int l, input int c);
    return (start_c[l] < 0) || ((c - start_c[l] - 1) > LOG_N * (BEATS + pl_of(l)));
  endfunction

  task automatic flush(input int l, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (i >= 0) hv[l][i] = 1'b0;
  endtask

  task automatic cmp(input string nm, input int l, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d cyc%0d: got %0d expected %0d", nm, l, c, act, exp);
    end
  endtask

  task automatic step(input bit st, input bit ab, input bit rl);
    ev_t ev;
    @(posedge clk);
    #1;
    cyc++;
    if (rl) begin
      for (int l = 0; l < NL; l++) begin
        start_c[l] = -1;
        flush(l, cyc - pl_of(l), cyc - 1);
      end
    end
    ev.c = cyc;
    for (int l = 0; l < NL; l++) begin
      ev.e[l]     = model(l, cyc);
      hv[l][cyc]  = ev.e[l].rd_en;
      hs[l][cyc]  = ev.e[l].stage;
      hb[l][cyc]  = ev.e[l].beat;
    end
    expq.push_back(ev);
    in_start = st;
    abort_i  = ab;
    if (rl && rst_n) begin
      rst_n = 1'b0;
      #1;
      for (int l = 0; l < NL; l++) cmp("async_rst_outputs", l, cyc, 32'(get_act(l)), 32'(0));
    end else begin
      rst_n = !rl;
    end
    if (!rl) begin
      for (int l = 0; l < NL; l++) begin
        if (ab) begin
          flush(l, cyc + 1 - pl_of(l), cyc);
          start_c[l] = -1;
        end else if (st && idle(l, cyc)) begin
          start_c[l] = cyc;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    ev_t  ev;
    out_t a;
    out_t e;
    if (expq.size() > 0) begin
      ev = expq.pop_front();
      if (done_o[0]) last_done0 = ev.c;
      for (int l = 0; l < NL; l++) begin
        a = get_act(l);
        e = ev.e[l];
        cmp("busy", l, ev.c, 32'(a.busy), 32'(e.busy));
        cmp("done", l, ev.c, 32'(a.done), 32'(e.done));
        cmp("rd_en", l, ev.c, 32'(a.rd_en), 32'(e.rd_en));
        cmp("stage_idx", l, ev.c, 32'(a.stage), 32'(e.stage));
        cmp("rd_bank", l, ev.c, 32'(a.rd_bank), 32'(e.rd_bank));
        cmp("wr_en", l, ev.c, 32'(a.wr_en), 32'(e.wr_en));
        if (!(e.busy && !e.rd_en)) begin
          cmp("beat_idx", l, ev.c, 32'(a.beat), 32'(e.beat));
          cmp("tw_addr", l, ev.c, 32'(a.tw), 32'(e.tw));
        end
        if (e.wr_en) begin
          cmp("wr_bank", l, ev.c, 32'(a.wr_bank), 32'(e.wr_bank));
          cmp("wr_beat", l, ev.c, 32'(a.wr_beat), 32'(e.wr_beat));
          cmp("perm_sel", l, ev.c, 32'(a.perm), 32'(e.perm));
        end
      end
    end
  end

  initial begin
    int t0;
    int r;
    rst_n    = 1'b0;
    in_start = 1'b0;
    abort_i  = 1'b0;
    cyc      = -1;
    for (int l = 0; l < NL; l++) start_c[l] = -1;

    repeat (3) step(0, 0, 1);
    repeat (10) step(0, 0, 0);

    // Nominal run, ignored restarts at 50 and in the done cycle, restart at 363 aborted 40 cycles later.
    t0 = cyc + 1;
    step(1, 0, 0);
    while (cyc < t0 + 413) begin
      r = cyc + 1 - t0;
      step(r == 50 || r == 361 || r == 363, r == 403, 0);
    end
    cmp("done_cycle_first_run", 0, cyc, 32'(last_done0 - t0), 32'(361));

    t0 = cyc + 1;
    step(1, 0, 0);
    while (cyc < t0 + 400) step(0, 0, 0);
    cmp("done_cycle_after_abort", 0, cyc, 32'(last_done0 - t0), 32'(361));

    // Reset mid-transform, then a clean run.
    t0 = cyc + 1;
    step(1, 0, 0);
    while (cyc < t0 + 199) step(0, 0, 0);
    repeat (3) step(0, 0, 1);
    repeat (5) step(0, 0, 0);
    cmp("no_done_after_reset", 0, cyc, 32'(last_done0 < t0), 32'(1));
    t0 = cyc + 1;
    step(1, 0, 0);
    while (cyc < t0 + 400) step(0, 0, 0);
    cmp("done_cycle_after_reset", 0, cyc, 32'(last_done0 - t0), 32'(361));

    repeat (3000) step($urandom_range(0, 19) == 0, $urandom_range(0, 599) == 0, 0);
    repeat (3) step(0, 0, 0);
    @(negedge clk);
    #1;
    cmp("scoreboard_drained", 0, cyc, 32'(expq.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
